fifo_sum_n: RTL

Parametrised N-input FIFO-to-FIFO combiner for the FM demodulation datapath, such as merging left/right channel terms, de-emphasis taps or multi-path audio sums. Each result consumes one sample from every input FIFO and computes a per-channel signed add or subtract. The sum is then optionally scaled down by an arithmetic shift and either saturated or wrapped to the output width. A one-entry output register sustains one result per clock while the inputs are non-empty and the output is not full.

---
 rtl/fifo_sum_n.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_sum_n.sv
// N-input FIFO-to-FIFO signed combiner: one sample per channel per result,
// per-channel add/subtract, arithmetic scale-down, then saturate or wrap.
module fifo_sum_n #(
  parameter int unsigned       NUM_IN     = 2,
  parameter int unsigned       DATA_WIDTH = 32,
  parameter logic [NUM_IN-1:0] SUB_MASK   = '0,
  parameter int unsigned       OUT_SHIFT  = 0,
  parameter bit                SATURATE   = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [NUM_IN-1:0]              in_rd_en,
  input  logic [NUM_IN-1:0]              in_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   in_dout,
  output logic                           out_wr_en,
  input  logic                           out_full,
  output logic [DATA_WIDTH-1:0]          out_din,
  output logic                           sat_pulse
);

  // Extra headroom bit keeps negation of the most negative sample exact.
  localparam int unsigned EW = DATA_WIDTH + $clog2(NUM_IN) + 1;

  if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
    $error("fifo_sum_n: NUM_IN must be in 2..8");
  end
  if (OUT_SHIFT > 8) begin : g_bad_out_shift
    $error("fifo_sum_n: OUT_SHIFT must be in 0..8");
  end

  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  result;
  logic [DATA_WIDTH-1:0]  next_result;
  logic                   clamp;
  logic                   drain;
  logic                   accept;
  logic signed [EW-1:0]   term;
  logic signed [EW-1:0]   sum;
  logic signed [EW-1:0]   shifted;
  logic signed [EW-1:0]   max_v;
  logic signed [EW-1:0]   min_v;

  assign max_v = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  assign min_v = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    sum  = '0;
    term = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      term = {{(EW-DATA_WIDTH){in_dout[i*DATA_WIDTH+DATA_WIDTH-1]}},
              in_dout[i*DATA_WIDTH +: DATA_WIDTH]};
      if (SUB_MASK[i]) sum = sum - term;
      else             sum = sum + term;
    end
    shifted     = sum >>> OUT_SHIFT;
    next_result = shifted[DATA_WIDTH-1:0];
    clamp       = 1'b0;
    if (SATURATE) begin
      if (shifted > max_v) begin
        next_result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        clamp       = 1'b1;
      end else if (shifted < min_v) begin
        next_result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        clamp       = 1'b1;
      end
    end
  end

  assign drain     = out_valid & ~out_full;
  assign accept    = (&(~in_empty)) & (~out_valid | drain) & ~reset;
  assign in_rd_en  = {NUM_IN{accept}};
  assign out_wr_en = drain;
  assign out_din   = result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      sat_pulse <= 1'b0;
    end else begin
      sat_pulse <= 1'b0;
      if (accept) begin
        result    <= next_result;
        out_valid <= 1'b1;
        sat_pulse <= clamp;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
